// File: rtl/serial_read_request_generator.sv
// serial_read_request_generator: turns one {base, stride, count} read job
// into a buffered stream of sequential requests with a done pulse.
//   ap_clk/areset        : clock, synchronous active-high reset
//   start_in, cfg_*      : job start and job parameters (taken in IDLE only)
//   req_valid/req_ready  : output handshake, head fields req_addr/seq/last
//   req_engine_id        : constant ENGINE_ID tag
//   busy_out, done_out   : job status; fifo_count_out: FIFO occupancy
module serial_read_request_generator #(
  parameter int ADDR_WIDTH = 64,
  parameter int ENGINE_ID  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          start_in,
  input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
  input  logic [15:0]                   cfg_stride,
  input  logic [31:0]                   cfg_count,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_WIDTH-1:0]         req_addr,
  output logic [31:0]                   req_seq,
  output logic                          req_last,
  output logic [7:0]                    req_engine_id,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_ext;
  logic [15:0]           stride_q;
  logic [31:0]           count_q;
  logic [31:0]           idx_q;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;

  logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
  logic [31:0]           mem_seq  [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];

  logic push;
  logic pop;
  logic is_last;
  logic fifo_full;
  logic start_acc;

  assign stride_ext = ADDR_WIDTH'(stride_q);
  assign is_last    = (idx_q == (count_q - 32'd1));
  // Full test uses registered occupancy only: a same-cycle pop
  // never frees a slot for a push.
  assign fifo_full  = (occ_q == CW'(FIFO_DEPTH));
  assign start_acc  = (state_q == IDLE) && start_in;

  assign req_valid = (occ_q != '0);
  assign pop       = req_valid && req_ready;
  assign occ_d     = occ_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = (cfg_count != 32'd0) ? GEN : DONE;
        end
      end
      GEN: begin
        push = !fifo_full;
        if (push && is_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Look at next occupancy so done follows the last pop by one cycle.
        if (occ_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (start_acc) begin
        addr_q   <= cfg_base_addr;
        stride_q <= cfg_stride;
        count_q  <= cfg_count;
        idx_q    <= '0;
      end else if (push) begin
        addr_q <= addr_q + stride_ext;
        if (!is_last) begin
          idx_q <= idx_q + 32'd1;
        end
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage is not reset; empty-FIFO outputs are forced to zero below.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= addr_q;
      mem_seq[wr_ptr_q]  <= idx_q;
      mem_last[wr_ptr_q] <= is_last;
    end
  end

  assign req_addr       = req_valid ? mem_addr[rd_ptr_q] : '0;
  assign req_seq        = req_valid ? mem_seq[rd_ptr_q]  : '0;
  assign req_last       = req_valid ? mem_last[rd_ptr_q] : 1'b0;
  assign req_engine_id  = 8'(ENGINE_ID);
  assign busy_out       = (state_q != IDLE);
  assign done_out       = (state_q == DONE);
  assign fifo_count_out = occ_q;

endmodule

// File: doc/serial_read_request_generator.md
# serial_read_request_generator

Upstream feeder for `serial_read_engine`. It converts one programmed read job into a stream of sequential cache read requests. A job is a base address, a byte stride and an element count. Requests are buffered in a small internal FIFO and presented on a valid/ready output that the engine's request-in FIFO consumes. Each job ends with a single-cycle completion pulse that the control chain uses to sequence the next setup phase.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: request address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- `ENGINE_ID`, 0: constant stamped into every request's `req_engine_id`.
- `FIFO_DEPTH`, 16: internal request FIFO entries; power of two, at least 2.

Ports:
- `ap_clk`  in  1: clock; all logic is on the rising edge.
- `areset`  in  1: reset; synchronous, active-high.
- `start_in`  in  1: job start pulse; sampled only in IDLE.
- `cfg_base_addr`  in  ADDR_WIDTH: first request address; latched on accepted start.
- `cfg_stride`  in  16: byte increment between requests; latched on accepted start.
- `cfg_count`  in  32: number of requests in the job; latched on accepted start.
- `req_valid`  out  1: FIFO head is valid.
- `req_ready`  in  1: consumer accepts the head this cycle.
- `req_addr`  out  ADDR_WIDTH: request address.
- `req_seq`  out  32: element index, 0 to count-1.
- `req_last`  out  1: marks the final request of the job.
- `req_engine_id`  out  8: equals ENGINE_ID.
- `busy_out`  out  1: high in GEN, DRAIN and DONE.
- `done_out`  out  1: one-cycle job-complete pulse.
- `fifo_count_out`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- FSM states are IDLE, GEN, DRAIN and DONE.
- IDLE → GEN on `start_in` with `cfg_count` != 0. On that edge, latch the config, set idx=0 and set next_addr=base.
- IDLE → DONE on `start_in` with `cfg_count`==0. No requests are produced.
- `start_in` is ignored in every state except IDLE. There is no queuing and no error flag.
- GEN, push rule: each cycle with occupancy < FIFO_DEPTH, push {next_addr, idx, idx==count-1}. Then idx += 1 and next_addr += stride, zero-extended, wrapping at 2^ADDR_WIDTH.
- GEN, push/pop interaction: the full check uses registered occupancy. A pop in the same cycle does not enable a push when the FIFO is full.
- GEN → DRAIN on the edge that pushes the entry with idx == count-1.
- DRAIN → DONE when occupancy==0, i.e. after the last entry has popped.
- DONE → IDLE unconditionally after 1 cycle. `done_out`=1 only in DONE.
- Pop rule: a pop occurs on every edge with `req_valid`&&`req_ready`.
- Output stability: `req_valid` = occupancy != 0. While `req_valid`=1 and `req_ready`=0, the head fields must hold stable.
- Occupancy update: occupancy' = occupancy + push − pop. Push and pop can both occur in one cycle.
- Counting limits: idx and occupancy never overflow. `cfg_count` = 2^32−1 is legal.

## Timing
- Reset values: all outputs are 0 (`req_engine_id` still equals ENGINE_ID). State=IDLE, FIFO empty, idx=0.
- Reset mid-job flushes the FIFO and drops the job. No `done_out` is issued.
- Start latency: start sampled at edge T. The state is GEN in cycle T+1 and the first entry is written at edge T+2. `req_valid`=1 from cycle T+2, so 2 cycles start-to-valid.
- Throughput: 1 request/cycle sustained while `req_ready`=1.
- Pass-through latency: 1 cycle from push to the head appearing (registered FIFO, no combinational bypass).
- Completion: `done_out` asserts the cycle after the edge that pops the last entry.
- Empty job: a zero-count start at edge T gives `done_out`=1 in cycle T+1 and `busy_out`=1 only in that cycle.
- `busy_out` rises the cycle after the accepted start and falls the cycle after DONE.

## Test plan
- Basic job: base=0x1000, stride=8, count=4, `req_ready`=1 → addresses 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; seq 0–3; `req_last` only on the fourth; `done_out` one cycle after the last pop.
- Backpressure: count=40 with `req_ready`=0 → `fifo_count_out` saturates at 16 and `req_valid` stays 1 with head fields stable. Then release `req_ready` → all 40 requests arrive in order, with no gaps or duplicates.
- Wrap-around: base=0xFFFF_FFFF_FFFF_FFF8, stride=16, count=2 → addresses 0x…FFF8 then 0x0000_0000_0000_0008.
- Zero count and ignored start: count=0 → no `req_valid`, `done_out` at T+1. A `start_in` pulsed during GEN of another job → no effect on that job's stream.
- Random ready: count=100 with `req_ready` toggled randomly → a scoreboard matches base+i·stride for i=0..99, and exactly one `done_out`.
- Reset mid-job: assert `areset` after 5 pops of a count=20 job → next cycle all outputs are 0 and occupancy is 0. A new start behaves like the basic job.
